xadc_drp_sequencer: RTL and testbench

Sequences DRP reads of the XADC auxiliary channels on behalf of the fabric. On every end-of-conversion pulse it picks the next enabled channel round-robin, issues one DRP read at that channel's status address, captures the 12-bit result into a per-channel holding register, and flags it valid. It sits between `xadc_wiz_0` (DRP port) and consumers such as the LED PWM logic, replacing ad-hoc `ready`-edge-clocked capture with a single-clock, fully synchronous controller.

---
 rtl/xadc_pkg.sv | 18 +
 rtl/xadc_rr_pick.sv | 35 +++
 rtl/xadc_drp_sequencer.sv | 140 ++++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared constants and types for the XADC DRP read sequencer and its helpers.
package xadc_pkg;

  localparam logic [6:0] XADC_ADDR_VAUX0  = 7'h10;
  localparam logic [6:0] XADC_ADDR_VAUX12 = 7'h1C;

  localparam int SAMPLE_W = 12;
  localparam int CH_IDX_W = 3;
  localparam int MAX_NCH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_STORE
  } seq_state_e;

endpackage

// File: rtl/xadc_rr_pick.sv
// Round-robin finder: first enabled channel strictly after ptr, wrapping modulo NCH.
module xadc_rr_pick
  import xadc_pkg::*;
#(
  parameter int NCH = 2
) (
  input  logic [CH_IDX_W-1:0] ptr,
  input  logic [NCH-1:0]      ch_en,
  output logic [CH_IDX_W-1:0] ch,
  output logic                any
);

  logic [MAX_NCH-1:0]  en_wide;
  logic [CH_IDX_W-1:0] idx;

  // NOTE: every variable written here gets a default before the loop so no
  // path leaves it unassigned (which would infer a latch); blocking '=' is
  // correct in combinational logic because later statements must see the
  // updated 'any'.
  always_comb begin
    en_wide            = '0;
    en_wide[NCH-1:0]   = ch_en;
    ch                 = '0;
    any                = 1'b0;
    idx                = '0;
    for (int k = 1; k <= NCH; k++) begin
      idx = CH_IDX_W'((int'(ptr) + k) % NCH);
      if (!any && en_wide[idx]) begin
        any = 1'b1;
        ch  = idx;
      end
    end
  end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Round-robin XADC DRP read sequencer with per-channel 12-bit holding registers.
// Optional DRP wait timeout is compiled in with `define XADC_SEQ_TIMEOUT_EN.
module xadc_drp_sequencer
  import xadc_pkg::*;
#(
  parameter int               NCH      = 2,
  parameter logic [NCH*7-1:0] CH_ADDRS = {XADC_ADDR_VAUX0, XADC_ADDR_VAUX12},
  parameter int               TIMEOUT  = 63
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          ch_en,
  input  logic                    eoc,
  input  logic                    drdy,
  input  logic [15:0]             do_in,
  output logic                    den,
  output logic [6:0]              daddr,
  output logic                    dwe,
  output logic                    busy,
  output logic [NCH*SAMPLE_W-1:0] sample,
  output logic                    sample_vld,
  output logic [2:0]              sample_ch,
  output logic                    timeout_err
);

  if (NCH < 1 || NCH > MAX_NCH || TIMEOUT < 1) begin : g_bad_params
    $error("xadc_drp_sequencer: NCH must be 1..8 and TIMEOUT at least 1");
  end

  seq_state_e          state;
  logic [CH_IDX_W-1:0] ptr;
  logic [CH_IDX_W-1:0] ch;
  logic                pend;
  logic [CH_IDX_W-1:0] pick_ch;
  logic                pick_any;
  logic                unused_do_low;

  // The low nibble of the DRP word is below the converter's 12-bit resolution.
  assign unused_do_low = ^do_in[3:0];
  assign dwe           = 1'b0;

  xadc_rr_pick #(.NCH(NCH)) u_pick (
    .ptr   (ptr),
    .ch_en (ch_en),
    .ch    (pick_ch),
    .any   (pick_any)
  );

`ifdef XADC_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
`endif

  // NOTE: the holding registers are flops, not a RAM, so they take the reset
  // like any other state; consumers rely on reading zero before first capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= CH_IDX_W'(NCH - 1);
      ch          <= '0;
      pend        <= 1'b0;
      den         <= 1'b0;
      daddr       <= '0;
      busy        <= 1'b0;
      sample      <= '0;
      sample_vld  <= 1'b0;
      sample_ch   <= '0;
      timeout_err <= 1'b0;
`ifdef XADC_SEQ_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      den         <= 1'b0;
      sample_vld  <= 1'b0;
      timeout_err <= 1'b0;

      // One-deep request memory for conversions that finish while we are busy.
      if (eoc && (|ch_en) && state != ST_IDLE) begin
        pend <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if ((eoc || pend) && pick_any) begin
            ch    <= pick_ch;
            daddr <= CH_ADDRS[int'(pick_ch)*7 +: 7];
            den   <= 1'b1;
            busy  <= 1'b1;
            pend  <= 1'b0;
            state <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          state <= ST_WAIT;
`ifdef XADC_SEQ_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end

        ST_WAIT: begin
          // Capture straight from the DRP bus so the result is visible the
          // cycle after drdy; STORE is the cycle the pulse is on the outputs.
          if (drdy) begin
            sample[int'(ch)*SAMPLE_W +: SAMPLE_W] <= do_in[15:4];
            sample_vld <= 1'b1;
            sample_ch  <= ch;
            state      <= ST_STORE;
          end
`ifdef XADC_SEQ_TIMEOUT_EN
          else if (wait_expired) begin
            timeout_err <= 1'b1;
            ptr         <= ch;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        ST_STORE: begin
          ptr   <= ch;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Directed/randomized bench for xadc_drp_sequencer; timeout steps run only
// when XADC_SEQ_TIMEOUT_EN is defined.
module tb_xadc_drp_sequencer;

  localparam int NCH = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NCH-1:0]        ch_en = '0;
  logic                  eoc = 1'b0;
  logic                  drdy = 1'b0;
  logic [15:0]           do_in = '0;
  logic                  den;
  logic [6:0]            daddr;
  logic                  dwe;
  logic                  busy;
  logic [NCH*12-1:0]     sample;
  logic                  sample_vld;
  logic [2:0]            sample_ch;
  logic                  timeout_err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state, derived from the channel selection rules.
  int         ptr_m;
  logic [11:0] samp_m [NCH];

  xadc_drp_sequencer #(.NCH(NCH), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_en       (ch_en),
    .eoc         (eoc),
    .drdy        (drdy),
    .do_in       (do_in),
    .den         (den),
    .daddr       (daddr),
    .dwe         (dwe),
    .busy        (busy),
    .sample      (sample),
    .sample_vld  (sample_vld),
    .sample_ch   (sample_ch),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int p, input logic [NCH-1:0] m);
    for (int k = 1; k <= NCH; k++) begin
      if (m[(p + k) % NCH]) return (p + k) % NCH;
    end
    return -1;
  endfunction

  function automatic logic [6:0] addr_of(input int c);
    return (c == 0) ? 7'h1C : 7'h10;
  endfunction

  function automatic logic [NCH*12-1:0] packed_model();
    logic [NCH*12-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*12 +: 12] = samp_m[i];
    return v;
  endfunction

  task automatic model_reset();
    ptr_m = NCH - 1;
    for (int i = 0; i < NCH; i++) samp_m[i] = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_den"}, den, 1'b0);
    check({tag, "_daddr"}, daddr, 7'h00);
    check({tag, "_dwe"}, dwe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_sample"}, sample, '0);
    check({tag, "_vld"}, sample_vld, 1'b0);
    check({tag, "_sch"}, sample_ch, 3'd0);
    check({tag, "_terr"}, timeout_err, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_reset_outputs("reset");
  endtask

  // One complete read: eoc, den next cycle, drdy d cycles after den (d >= 2).
  task automatic read_once(input logic [NCH-1:0] m, input logic [15:0] data,
                           input int d, input bit spurious, input logic [NCH-1:0] m_after);
    int c;
    c = pick(ptr_m, m);
    ch_en = m;
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    check("den_rise", den, 1'b1);
    check("daddr_issue", daddr, addr_of(c));
    check("busy_issue", busy, 1'b1);
    check("dwe_zero", dwe, 1'b0);
    ch_en = m_after;
    if (spurious) begin
      drdy = 1'b1;
      do_in = ~data;
    end
    @(negedge clk);
    drdy = 1'b0;
    check("den_single", den, 1'b0);
    check("daddr_hold", daddr, addr_of(c));
    repeat (d - 2) @(negedge clk);
    check("vld_idle_wait", sample_vld, 1'b0);
    drdy = 1'b1;
    do_in = data;
    @(negedge clk);
    drdy = 1'b0;
    samp_m[c] = data[15:4];
    ptr_m = c;
    check("vld_pulse", sample_vld, 1'b1);
    check("sample_ch", sample_ch, 3'(c));
    check("sample_val", sample, packed_model());
    @(negedge clk);
    check("vld_drop", sample_vld, 1'b0);
    check("busy_done", busy, 1'b0);
  endtask

  initial begin
    logic [NCH-1:0] m;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single-channel read with a 3-cycle DRP latency.
    read_once(2'b01, 16'hABC0, 3, 1'b0, 2'b01);
    check("first_low", sample[11:0], 12'hABC);

    // Alternating channels from reset: 0x1C, 0x10, 0x1C, 0x10.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      read_once(2'b11, 16'($urandom), 2 + (i % 3), 1'b0, 2'b11);
    end

    // Randomized masks, data, latency, spurious drdy and mid-read mask changes.
    for (int i = 0; i < 20; i++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      read_once(m, 16'($urandom), int'($urandom_range(2, 6)), 1'($urandom),
                NCH'($urandom));
    end

    // No channels enabled: eoc must be ignored and must not arm a pending read.
    ch_en = '0;
    for (int i = 0; i < 6; i++) begin
      eoc = 1'($urandom) | (i == 0);
      @(negedge clk);
      check("noen_den", den, 1'b0);
      check("noen_busy", busy, 1'b0);
    end
    eoc = 1'b0;
    ch_en = 2'b01;
    repeat (3) begin
      @(negedge clk);
      check("noen_no_pend", den, 1'b0);
    end

    // Two eoc pulses during WAIT: exactly one extra read follows STORE.
    ch_en = 2'b11;
    begin
      int c1, c2;
      c1 = pick(ptr_m, 2'b11);
      eoc = 1'b1;
      @(negedge clk);
      check("pend_den1", den, 1'b1);
      check("pend_addr1", daddr, addr_of(c1));
      @(negedge clk);                    // WAIT
      @(negedge clk);                    // eoc sampled in WAIT
      @(negedge clk);                    // second eoc, dropped
      eoc = 1'b0;
      drdy = 1'b1;
      do_in = 16'h1230;
      @(negedge clk);
      drdy = 1'b0;
      samp_m[c1] = 12'h123;
      ptr_m = c1;
      check("pend_vld1", sample_vld, 1'b1);
      check("pend_sample1", sample, packed_model());
      @(negedge clk);
      check("pend_gap", den, 1'b0);
      @(negedge clk);
      c2 = pick(ptr_m, 2'b11);
      check("pend_den2", den, 1'b1);
      check("pend_addr2", daddr, addr_of(c2));
      @(negedge clk);
      drdy = 1'b1;
      do_in = 16'h4560;
      @(negedge clk);
      drdy = 1'b0;
      samp_m[c2] = 12'h456;
      ptr_m = c2;
      check("pend_vld2", sample_vld, 1'b1);
      check("pend_ch2", sample_ch, 3'(c2));
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        check("pend_dropped", den, 1'b0);
      end
    end

    // Reset during WAIT, then a late drdy: nothing is captured.
    eoc = 1'b1;
    @(negedge clk);
    eoc = 1'b0;
    check("rstw_den", den, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drdy = 1'b1;
    do_in = 16'hFFF0;
    @(negedge clk);
    drdy = 1'b0;
    model_reset();
    check_reset_outputs("rstw");
    @(negedge clk);
    check("rstw_vld_late", sample_vld, 1'b0);
    check("rstw_sample_late", sample, '0);
    read_once(2'b11, 16'h0770, 2, 1'b0, 2'b11);

`ifdef XADC_SEQ_TIMEOUT_EN
    // DRP never answers: timeout_err 8 cycles after WAIT entry, channel skipped.
    begin
      int ct;
      ct = pick(ptr_m, 2'b11);
      eoc = 1'b1;
      @(negedge clk);
      eoc = 1'b0;
      check("to_den", den, 1'b1);
      @(negedge clk);                    // WAIT entry
      repeat (7) begin
        @(negedge clk);
        check("to_quiet", timeout_err, 1'b0);
      end
      @(negedge clk);
      check("to_pulse", timeout_err, 1'b1);
      check("to_busy", busy, 1'b0);
      check("to_sample", sample, packed_model());
      check("to_no_vld", sample_vld, 1'b0);
      ptr_m = ct;
      @(negedge clk);
      check("to_single", timeout_err, 1'b0);
      read_once(2'b11, 16'h9990, 3, 1'b0, 2'b11);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
